wb_csr_file: RTL and testbench

Machine-mode CSR storage and commit point at the write-back end of the pipeline. Consumes the per-CSR write data/valid pairs and the trap/return redirect (`clint_pc`) registered by the MEM/WB stage, plus generic `csrrw/csrrs/csrrc` results. It also:
- provides a combinational, write-first read port to decode;
- runs the `mcycle`/`minstret` counters;
- issues a registered one-cycle PC redirect to fetch.

---
 rtl/wb_csr_file_pkg.sv | 27 ++
 rtl/csr_counter64.sv | 44 ++++
 rtl/wb_csr_file.sv | 173 +++++++++++++++++
 tb/tb_wb_csr_file.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_csr_file_pkg.sv
// rtl/wb_csr_file_pkg.sv - CSR address map, mstatus masks and misa constant
//
// Purpose: shared constants for the write-back CSR file and its counters.
// Ports:   none (package).
package wb_csr_file_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    // MIE[3], MPIE[7], MPP[12:11] are the only stored mstatus bits.
    localparam logic [63:0] MSTATUS_WMASK   = 64'h0000_0000_0000_1888;
    // Machine mode only, so MPP always reads as M (2'b11).
    localparam logic [63:0] MSTATUS_MPP_SET = 64'h0000_0000_0000_1800;
    // MXL=2 (64-bit) in [63:62], extension I at bit 8.
    localparam logic [63:0] MISA_VALUE      = 64'h8000_0000_0000_0100;

    function automatic logic [63:0] mstatus_legalize(input logic [63:0] v);
        return (v & MSTATUS_WMASK) | MSTATUS_MPP_SET;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - wrapping counter with increment enable and load port
//
// Purpose: mcycle/minstret storage. Load beats increment; wraps silently.
// Ports:
//   clk          in  clock
//   rst          in  synchronous active-high reset (clears to 0)
//   inc_i        in  increment by one this cycle
//   load_i       in  load load_data_i this cycle (no increment applied)
//   load_data_i  in  W  load value
//   count_o      out W  current count (register output)
module csr_counter64 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_data_i;
        end else if (inc_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/wb_csr_file.sv
// rtl/wb_csr_file.sv - machine-mode CSR storage and commit point at write-back
//
// Purpose: holds trap CSRs and counters, resolves dedicated vs. generic writes,
//          offers a write-first read port to decode, and registers the
//          one-cycle PC redirect to fetch.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_csr_<x>_writedata/_write_valid dedicated trap/return writes (x = mstatus,
//                                    mepc, mcause, mtval, mtvec)
//   i_csr_wen/i_csr_addr/i_csr_wdata generic CSR instruction write
//   i_retire                        one instruction retired
//   i_clint_pc/i_clint_pc_valid     redirect request
//   i_rd_addr -> o_rd_data/o_rd_illegal  combinational read port
//   o_mtvec, o_mepc, o_mie          architectural register outputs
//   o_redirect_valid/o_redirect_pc  registered redirect to fetch
module wb_csr_file
    import wb_csr_file_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   i_csr_mstatus_writedata,
    input  logic              i_csr_mstatus_write_valid,
    input  logic [XLEN-1:0]   i_csr_mepc_writedata,
    input  logic              i_csr_mepc_write_valid,
    input  logic [XLEN-1:0]   i_csr_mcause_writedata,
    input  logic              i_csr_mcause_write_valid,
    input  logic [XLEN-1:0]   i_csr_mtval_writedata,
    input  logic              i_csr_mtval_write_valid,
    input  logic [XLEN-1:0]   i_csr_mtvec_writedata,
    input  logic              i_csr_mtvec_write_valid,
    input  logic              i_csr_wen,
    input  logic [CSR_AW-1:0] i_csr_addr,
    input  logic [XLEN-1:0]   i_csr_wdata,
    input  logic              i_retire,
    input  logic [XLEN-1:0]   i_clint_pc,
    input  logic              i_clint_pc_valid,
    input  logic [CSR_AW-1:0] i_rd_addr,
    output logic [XLEN-1:0]   o_rd_data,
    output logic              o_rd_illegal,
    output logic [XLEN-1:0]   o_mtvec,
    output logic [XLEN-1:0]   o_mepc,
    output logic              o_mie,
    output logic              o_redirect_valid,
    output logic [XLEN-1:0]   o_redirect_pc
);

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q,   mtvec_d;
    logic [XLEN-1:0] mepc_q,    mepc_d;
    logic [XLEN-1:0] mcause_q,  mcause_d;
    logic [XLEN-1:0] mtval_q,   mtval_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q,    redir_pc_d;
    logic [XLEN-1:0] mcycle, minstret;

    logic gen_mstatus, gen_mtvec, gen_mepc, gen_mcause, gen_mtval;
    logic gen_mcycle, gen_minstret;

    assign gen_mstatus  = i_csr_wen && (i_csr_addr == CSR_MSTATUS);
    assign gen_mtvec    = i_csr_wen && (i_csr_addr == CSR_MTVEC);
    assign gen_mepc     = i_csr_wen && (i_csr_addr == CSR_MEPC);
    assign gen_mcause   = i_csr_wen && (i_csr_addr == CSR_MCAUSE);
    assign gen_mtval    = i_csr_wen && (i_csr_addr == CSR_MTVAL);
    assign gen_mcycle   = i_csr_wen && (i_csr_addr == CSR_MCYCLE);
    assign gen_minstret = i_csr_wen && (i_csr_addr == CSR_MINSTRET);

    // Next-state values double as the write-first bypass for the read port,
    // so masks and dedicated-over-generic priority live in one place.
    always_comb begin
        mstatus_d = mstatus_q;
        if (i_csr_mstatus_write_valid) begin
            mstatus_d = mstatus_legalize(i_csr_mstatus_writedata);
        end else if (gen_mstatus) begin
            mstatus_d = mstatus_legalize(i_csr_wdata);
        end

        mtvec_d = mtvec_q;
        if (i_csr_mtvec_write_valid) begin
            mtvec_d = {i_csr_mtvec_writedata[XLEN-1:2], 2'b00};
        end else if (gen_mtvec) begin
            mtvec_d = {i_csr_wdata[XLEN-1:2], 2'b00};
        end

        mepc_d = mepc_q;
        if (i_csr_mepc_write_valid) begin
            mepc_d = {i_csr_mepc_writedata[XLEN-1:2], 2'b00};
        end else if (gen_mepc) begin
            mepc_d = {i_csr_wdata[XLEN-1:2], 2'b00};
        end

        mcause_d = mcause_q;
        if (i_csr_mcause_write_valid) begin
            mcause_d = i_csr_mcause_writedata;
        end else if (gen_mcause) begin
            mcause_d = i_csr_wdata;
        end

        mtval_d = mtval_q;
        if (i_csr_mtval_write_valid) begin
            mtval_d = i_csr_mtval_writedata;
        end else if (gen_mtval) begin
            mtval_d = i_csr_wdata;
        end

        redir_valid_d = i_clint_pc_valid;
        redir_pc_d    = i_clint_pc_valid ? i_clint_pc : redir_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q     <= MSTATUS_MPP_SET;
            mtvec_q       <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            mstatus_q     <= mstatus_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    csr_counter64 #(.W(XLEN)) u_mcycle (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (1'b1),
        .load_i      (gen_mcycle),
        .load_data_i (i_csr_wdata),
        .count_o     (mcycle)
    );

    csr_counter64 #(.W(XLEN)) u_minstret (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (i_retire),
        .load_i      (gen_minstret),
        .load_data_i (i_csr_wdata),
        .count_o     (minstret)
    );

    // Counters bypass only a same-cycle load, never the pending increment.
    always_comb begin
        o_rd_data    = '0;
        o_rd_illegal = 1'b0;
        case (i_rd_addr)
            CSR_MSTATUS:  o_rd_data = mstatus_d;
            CSR_MISA:     o_rd_data = MISA_VALUE;
            CSR_MTVEC:    o_rd_data = mtvec_d;
            CSR_MEPC:     o_rd_data = mepc_d;
            CSR_MCAUSE:   o_rd_data = mcause_d;
            CSR_MTVAL:    o_rd_data = mtval_d;
            CSR_MCYCLE:   o_rd_data = gen_mcycle   ? i_csr_wdata : mcycle;
            CSR_MINSTRET: o_rd_data = gen_minstret ? i_csr_wdata : minstret;
            default:      o_rd_illegal = 1'b1;
        endcase
    end

    assign o_mtvec          = mtvec_q;
    assign o_mepc           = mepc_q;
    assign o_mie            = mstatus_q[3];
    assign o_redirect_valid = redir_valid_q;
    assign o_redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_wb_csr_file.sv
// tb/tb_wb_csr_file.sv - self-checking bench for wb_csr_file
module tb_wb_csr_file;

    localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ms_wd, mepc_wd, mcause_wd, mtval_wd, mtvec_wd;
    logic        ms_wv, mepc_wv, mcause_wv, mtval_wv, mtvec_wv;
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        retire;
    logic [63:0] cpc;
    logic        cpc_v;
    logic [11:0] raddr;
    logic [63:0] rd_data;
    logic        rd_illegal;
    logic [63:0] mtvec_o, mepc_o, rpc;
    logic        mie, rvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_csr_file #(.XLEN(64), .CSR_AW(12)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .i_csr_mstatus_writedata   (ms_wd),
        .i_csr_mstatus_write_valid (ms_wv),
        .i_csr_mepc_writedata      (mepc_wd),
        .i_csr_mepc_write_valid    (mepc_wv),
        .i_csr_mcause_writedata    (mcause_wd),
        .i_csr_mcause_write_valid  (mcause_wv),
        .i_csr_mtval_writedata     (mtval_wd),
        .i_csr_mtval_write_valid   (mtval_wv),
        .i_csr_mtvec_writedata     (mtvec_wd),
        .i_csr_mtvec_write_valid   (mtvec_wv),
        .i_csr_wen                 (wen),
        .i_csr_addr                (waddr),
        .i_csr_wdata               (wdata),
        .i_retire                  (retire),
        .i_clint_pc                (cpc),
        .i_clint_pc_valid          (cpc_v),
        .i_rd_addr                 (raddr),
        .o_rd_data                 (rd_data),
        .o_rd_illegal              (rd_illegal),
        .o_mtvec                   (mtvec_o),
        .o_mepc                    (mepc_o),
        .o_mie                     (mie),
        .o_redirect_valid          (rvalid),
        .o_redirect_pc             (rpc)
    );

    typedef struct {
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic [11:0] raddr;
        logic [63:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ms_wv = 0; mepc_wv = 0; mcause_wv = 0; mtval_wv = 0; mtvec_wv = 0;
        ms_wd = '0; mepc_wd = '0; mcause_wd = '0; mtval_wd = '0; mtvec_wd = '0;
        wen = 0; waddr = '0; wdata = '0; retire = 0; cpc = '0; cpc_v = 0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp);
        raddr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        idle();
        rst = 1;
        raddr = '0;

        // Reset held three cycles.
        tick(); tick(); tick();
        rd("rst_mstatus", 12'h300, 64'h1800);
        rd("rst_mtvec",   12'h305, 64'h0);
        rd("rst_mepc",    12'h341, 64'h0);
        rd("rst_mcause",  12'h342, 64'h0);
        rd("rst_mtval",   12'h343, 64'h0);
        chk("rst_redirect_valid", {63'd0, rvalid}, 64'd0);
        chk("rst_redirect_pc", rpc, 64'd0);
        rst = 0;
        rd("mcycle_0", 12'hB00, 64'd0);
        tick();
        rd("mcycle_1", 12'hB00, 64'd1);
        tick();
        rd("mcycle_2", 12'hB00, 64'd2);
        rd("minstret_rst", 12'hB02, 64'd0);

        // Generic writes with write-first reads.
        vecs[0] = '{1'b1, 12'h305, 64'h8000_0003, 12'h305, 64'h8000_0000, 1'b0};
        vecs[1] = '{1'b0, 12'h000, 64'h0,         12'h305, 64'h8000_0000, 1'b0};
        vecs[2] = '{1'b1, 12'h342, 64'hDEAD_BEEF_0000_0001, 12'h342, 64'hDEAD_BEEF_0000_0001, 1'b0};
        vecs[3] = '{1'b1, 12'h343, 64'h55,        12'h343, 64'h55,        1'b0};
        vecs[4] = '{1'b1, 12'h300, 64'h8,         12'h300, 64'h1808,      1'b0};
        vecs[5] = '{1'b1, 12'h301, 64'h0,         12'h301, MISA,          1'b0};
        vecs[6] = '{1'b0, 12'h000, 64'h0,         12'h301, MISA,          1'b0};
        vecs[7] = '{1'b1, 12'h7C0, 64'hFF,        12'h7C0, 64'h0,         1'b1};
        vecs[8] = '{1'b1, 12'h341, 64'h1237,      12'h341, 64'h1234,      1'b0};
        vecs[9] = '{1'b1, 12'h305, 64'h44,        12'h300, 64'h1808,      1'b0};
        for (int i = 0; i < 10; i++) begin
            wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_illegal", i), {63'd0, rd_illegal}, {63'd0, vecs[i].exp_ill});
            tick();
        end
        idle();
        chk("vec_o_mtvec", mtvec_o, 64'h44);
        chk("vec_o_mepc", mepc_o, 64'h1234);
        chk("vec_o_mie", {63'd0, mie}, 64'd1);

        // Trap entry.
        mepc_wv = 1; mepc_wd = 64'h8000_0013;
        mcause_wv = 1; mcause_wd = 64'd11;
        ms_wv = 1; ms_wd = 64'hFFFF_FFFF;
        cpc_v = 1; cpc = 64'h8000_0100;
        tick();
        idle();
        chk("trap_o_mepc", mepc_o, 64'h8000_0010);
        rd("trap_mstatus", 12'h300, 64'h1888);
        rd("trap_mcause", 12'h342, 64'd11);
        chk("trap_redirect_valid", {63'd0, rvalid}, 64'd1);
        chk("trap_redirect_pc", rpc, 64'h8000_0100);
        tick();
        chk("trap_redirect_once", {63'd0, rvalid}, 64'd0);

        // Back-to-back redirects.
        cpc_v = 1; cpc = 64'hA0;
        tick();
        cpc = 64'hB0;
        chk("b2b_pc0", rpc, 64'hA0);
        tick();
        idle();
        chk("b2b_valid1", {63'd0, rvalid}, 64'd1);
        chk("b2b_pc1", rpc, 64'hB0);

        // Dedicated write beats generic write; other generic CSR still commits elsewhere.
        wen = 1; waddr = 12'h341; wdata = 64'h1234;
        mepc_wv = 1; mepc_wd = 64'h5678;
        rd("collide_bypass", 12'h341, 64'h5678);
        tick();
        idle();
        chk("collide_o_mepc", mepc_o, 64'h5678);
        wen = 1; waddr = 12'h343; wdata = 64'h77;
        mtvec_wv = 1; mtvec_wd = 64'h200;
        tick();
        idle();
        rd("split_mtval", 12'h343, 64'h77);
        chk("split_o_mtvec", mtvec_o, 64'h200);

        // Counter load beats increment, then wraps.
        wen = 1; waddr = 12'hB00; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        rd("mcycle_load_bypass", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        idle();
        rd("mcycle_loaded", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd("mcycle_wrap", 12'hB00, 64'd0);

        wen = 1; waddr = 12'hB02; wdata = 64'd5; retire = 1;
        tick();
        idle();
        rd("minstret_load", 12'hB02, 64'd5);
        retire = 1;
        tick();
        idle();
        rd("minstret_inc", 12'hB02, 64'd6);

        // Reset in the same cycle as a redirect request and writes.
        rst = 1;
        cpc_v = 1; cpc = 64'hCAFE_0000;
        mepc_wv = 1; mepc_wd = 64'h4444;
        wen = 1; waddr = 12'h342; wdata = 64'h9;
        tick();
        idle();
        chk("rstmid_redirect_valid", {63'd0, rvalid}, 64'd0);
        chk("rstmid_redirect_pc", rpc, 64'd0);
        chk("rstmid_o_mepc", mepc_o, 64'd0);
        chk("rstmid_o_mtvec", mtvec_o, 64'd0);
        chk("rstmid_o_mie", {63'd0, mie}, 64'd0);
        rd("rstmid_mstatus", 12'h300, 64'h1800);
        rd("rstmid_mcause", 12'h342, 64'd0);
        rd("rstmid_mtval", 12'h343, 64'd0);
        rd("rstmid_mcycle", 12'hB00, 64'd0);
        rd("rstmid_minstret", 12'hB02, 64'd0);
        rst = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
